// File: rtl/speed_pkg.sv
// Shared types and defaults for the wheel-speed sampling path.
package speed_pkg;
    localparam int DEFAULT_ANGLE_W = 32;
    localparam int DEFAULT_N_CH    = 2;

    typedef enum logic [1:0] {WAIT, CALC, HOLD} state_t;

    typedef logic signed [DEFAULT_ANGLE_W-1:0] omega_t;
endpackage

// File: rtl/speed_sample_ctrl_if.sv
// Omega result channel: per-channel angle delta with valid/ready handshake.
interface speed_sample_ctrl_if
    import speed_pkg::*;
#(
    parameter int ANGLE_W = DEFAULT_ANGLE_W,
    parameter int CH_W    = 1
) ();
    logic [ANGLE_W-1:0] omega_data;
    logic [CH_W-1:0]    omega_ch;
    logic               omega_valid;
    logic               omega_ready;

    modport master (output omega_data, omega_ch, omega_valid, input omega_ready);
    modport slave  (input omega_data, omega_ch, omega_valid, output omega_ready);
endinterface

// File: rtl/speed_period_timer.sv
// Sampling tick generator: down-counter that ticks on zero and reloads with period.
module speed_period_timer #(
    parameter int PERIOD_W = 25
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] period,
    output logic                tick
);
    logic [PERIOD_W-1:0] count;

    // Holding the counter at zero while disabled makes the first enabled cycle tick.
    assign tick = enable && (count == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (!enable) begin
            count <= '0;
        end else if (tick) begin
            count <= period;
        end else begin
            count <= count - 1'b1;
        end
    end
endmodule

// File: rtl/speed_sample_ctrl.sv
// Wheel-speed sampling scheduler: snapshots all angle counters on a tick and
// streams per-channel deltas through one shared subtractor.
//
//   state | meaning
//   WAIT  | idle, waiting for a sampling tick
//   CALC  | register cur[ch]-prev[ch] and ch into the output
//   HOLD  | omega_valid high until the consumer accepts
module speed_sample_ctrl
    import speed_pkg::*;
#(
    parameter int N_CH     = DEFAULT_N_CH,
    parameter int ANGLE_W  = DEFAULT_ANGLE_W,
    parameter int PERIOD_W = 25,
    parameter int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic [PERIOD_W-1:0]            period,
    input  logic [N_CH-1:0][ANGLE_W-1:0]   angle,
    speed_sample_ctrl_if.master            omega_if,
    output logic                           overrun,
    input  logic                           overrun_clr,
    output logic                           busy
);
    logic               tick;
    state_t             state, state_nxt;
    logic [CH_W-1:0]    ch, ch_nxt;
    logic               primed;
    logic               snap, calc, last_ch, late_tick;
    logic [ANGLE_W-1:0] cur  [N_CH];
    logic [ANGLE_W-1:0] prev [N_CH];
    logic [ANGLE_W-1:0] omega_data_q;
    logic [CH_W-1:0]    omega_ch_q;

    speed_period_timer #(.PERIOD_W(PERIOD_W)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .period (period),
        .tick   (tick)
    );

    assign last_ch   = (ch == CH_W'(N_CH - 1));
    assign late_tick = tick && (state != WAIT);

    always_comb begin
        state_nxt = state;
        ch_nxt    = ch;
        snap      = 1'b0;
        calc      = 1'b0;
        unique case (state)
            WAIT: begin
                if (tick) begin
                    snap = 1'b1;
                    if (primed) begin
                        state_nxt = CALC;
                        ch_nxt    = '0;
                    end
                end
            end
            CALC: begin
                calc      = 1'b1;
                state_nxt = HOLD;
            end
            HOLD: begin
                if (omega_if.omega_ready) begin
                    if (last_ch) begin
                        state_nxt = WAIT;
                    end else begin
                        ch_nxt    = ch + CH_W'(1);
                        state_nxt = CALC;
                    end
                end
            end
            default: state_nxt = WAIT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= WAIT;
            ch    <= '0;
        end else begin
            state <= state_nxt;
            ch    <= ch_nxt;
        end
    end

    // A late tick drops its snapshot and unprimes, so every delta spans one window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            primed       <= 1'b0;
            overrun      <= 1'b0;
            omega_data_q <= '0;
            omega_ch_q   <= '0;
            for (int i = 0; i < N_CH; i++) begin
                cur[i]  <= '0;
                prev[i] <= '0;
            end
        end else begin
            if (!enable || late_tick) begin
                primed <= 1'b0;
            end else if (snap) begin
                primed <= 1'b1;
            end

            if (late_tick) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end

            if (snap) begin
                for (int i = 0; i < N_CH; i++) begin
                    prev[i] <= cur[i];
                    cur[i]  <= angle[i];
                end
            end

            if (calc) begin
                omega_data_q <= cur[ch] - prev[ch];
                omega_ch_q   <= ch;
            end
        end
    end

    assign omega_if.omega_data  = omega_data_q;
    assign omega_if.omega_ch    = omega_ch_q;
    assign omega_if.omega_valid = (state == HOLD);
    assign busy                 = (state != WAIT);
endmodule
